// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with one unified memory and one shared ALU.
// Optional jump support is built when the macro MIPS_MC_JUMP_EN is defined.
module mips_multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic [5:0]             opcode_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic                   iord_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic                   ir_write_o,
  output logic                   pc_write_o,
  output logic [1:0]             pc_src_o,
  output logic                   alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic [2:0]             alu_op_o,
  output logic                   ext_zero_o,
  output logic                   reg_dst_o,
  output logic                   mem_to_reg_o,
  output logic                   reg_write_o,
  output logic                   illegal_op_o,
  output logic [3:0]             state_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10
`ifdef MIPS_MC_JUMP_EN
    , S_JUMP    = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;

  state_e                 state_q, state_d;
  logic                   ext_zero_q, ext_zero_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   retire;
  logic                   illegal;
  logic                   mem_read, mem_write, ir_write, pc_write, reg_write;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ext_zero_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ext_zero_q <= ext_zero_d;
      if (retire) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_d      = state_q;
    ext_zero_d   = ext_zero_q;
    retire       = 1'b0;
    illegal      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    iord_o       = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALU_ADD;
    ext_zero_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (enable_i) begin
          mem_read    = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write    = mem_ready_i;
          pc_write    = mem_ready_i;
          if (mem_ready_i) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_IMM_EXEC;
`ifdef MIPS_MC_JUMP_EN
          OP_J:           state_d = S_JUMP;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord_o   = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst_o = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = 2'b01;
        pc_write    = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_IMM_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
        ext_zero_o  = (opcode_i == OP_ORI);
        ext_zero_d  = (opcode_i == OP_ORI);
        state_d     = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write  = 1'b1;
        ext_zero_o = ext_zero_q;   // IR no longer consulted here
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MIPS_MC_JUMP_EN
      S_JUMP: begin
        pc_src_o = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Reset silences every write strobe so an aborted instruction leaves no side effects.
  assign mem_read_o    = mem_read  & ~reset;
  assign mem_write_o   = mem_write & ~reset;
  assign ir_write_o    = ir_write  & ~reset;
  assign pc_write_o    = pc_write  & ~reset;
  assign reg_write_o   = reg_write & ~reset;
  assign illegal_op_o  = illegal   & ~reset;
  assign state_o       = state_q;
  assign instr_count_o = count_q;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control state machine for the multicycle MIPS datapath variant, where one unified memory holds instructions and data, and one ALU computes PC+4, branch targets and results. It replaces the single-cycle opcode decoder in that variant. It sequences each instruction through fetch, decode, execute, memory and write-back steps, waits on a memory-ready handshake, and resolves beq/bne. It also keeps a retired-instruction count for bring-up.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable_i  in  1  allows a new fetch to start
- opcode_i  in  6  instruction register bits [31:26]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  unified memory completes the current access this cycle
- iord_o  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  load the instruction register
- pc_write_o  out  1  load the PC
- pc_src_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a_o  out  1  ALU A operand: 0 = PC, 1 = A register
- alu_src_b_o  out  2  ALU B operand: 00 = B register, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- alu_op_o  out  3  ALU op: 000 = add, 001 = sub, 010 = decode by funct, 011 = or
- ext_zero_o  out  1  zero-extend the immediate instead of sign-extending it
- reg_dst_o  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg_o  out  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_write_o  out  1  register file write
- illegal_op_o  out  1  one-cycle pulse when an unsupported opcode is decoded
- state_o  out  4  current state, for debug
- instr_count_o  out  COUNT_WIDTH  number of retired instructions

## Operation
- The state register is 4 bits: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, IMM_EXEC=9, IMM_WB=10, JUMP=11. Codes 12–15 go to FETCH.
- FETCH:
  - When enable_i=0, stay in FETCH with all strobes 0.
  - Otherwise drive mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=000, pc_src_o=00.
  - In the cycle mem_ready_i=1, pulse ir_write_o=1 and pc_write_o=1, then go to DECODE. Otherwise hold.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=000 (precomputes the branch target). Next state by opcode_i:
  - 0x00 → R_EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 or 0x05 → BRANCH
  - 0x08 or 0x0D → IMM_EXEC
  - 0x02 → JUMP (only with the jump macro)
  - any other opcode → FETCH, with illegal_op_o=1 for that cycle
- MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000. Go to MEM_READ for lw (0x23), MEM_WRITE for sw (0x2B).
- MEM_READ: mem_read_o=1, iord_o=1. Hold until mem_ready_i=1, then go to MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1. Go to FETCH.
- MEM_WRITE: mem_write_o=1, iord_o=1. Hold until mem_ready_i=1, then go to FETCH.
- R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=010. Go to R_WB.
- R_WB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0. Go to FETCH.
- BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=001, pc_src_o=01.
  - pc_write_o = zero_i for beq, ~zero_i for bne.
  - Go to FETCH.
- IMM_EXEC: alu_src_a_o=1, alu_src_b_o=10.
  - addi: alu_op_o=000, ext_zero_o=0.
  - ori: alu_op_o=011, ext_zero_o=1.
  - Go to IMM_WB.
- IMM_WB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0. Go to FETCH.
- During IMM_WB, ext_zero_o keeps its IMM_EXEC value.
- Every output not listed for a state is 0.
- opcode_i is read in DECODE, MEM_ADDR, BRANCH and IMM_EXEC; the IR is stable in these states.
- instr_count_o increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, IMM_WB or JUMP. It wraps modulo 2^COUNT_WIDTH.
- An illegal opcode does not increment instr_count_o.

## Timing
- Reset:
  - The clock edge with reset=1 sets state=FETCH, instr_count_o=0 and clears the illegal_op_o pulse.
  - While reset=1, every strobe output is forced to 0: mem_read_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o.
  - Reset mid-instruction aborts the instruction with no further writes.
- Output decoding:
  - Most outputs are Moore outputs, decoded combinationally from the state register.
  - ir_write_o and pc_write_o in FETCH are Mealy outputs, gated by mem_ready_i.
  - pc_write_o in BRANCH is a Mealy output, gated by zero_i.
- Cycles per instruction with zero wait states (mem_ready_i held at 1):
  - lw 5; sw 4; R-type 4; addi/ori 4; beq/bne 3; j 3.
- Each cycle mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. The request outputs stay asserted and unchanged during the wait.
- enable_i is sampled only in FETCH. Deasserting it mid-instruction lets the current instruction complete.
- If enable_i=0 and mem_ready_i=1 in FETCH, no fetch occurs.

## Configuration
- MIPS_MC_JUMP_EN defined:
  - Opcode 0x02 goes DECODE → JUMP.
  - JUMP drives pc_src_o=10, pc_write_o=1, then goes to FETCH.
- MIPS_MC_JUMP_EN undefined:
  - The JUMP state is absent and opcode 0x02 is illegal (illegal_op_o pulse, return to FETCH).
  - pc_src_o never equals 10.

## Test plan
- Reset held 2 cycles, then released with enable_i=1, mem_ready_i=1 → state_o=0, instr_count_o=0, and all strobes 0 during reset. The first cycle after release has mem_read_o=1 and ir_write_o=1.
- lw (0x23) with mem_ready_i=1 → states 0,1,2,3,4, then back to 0. reg_write_o=1 and mem_to_reg_o=1 only in state 4. instr_count_o goes to 1.
- sw (0x2B) with mem_ready_i low for 3 cycles in MEM_WRITE → mem_write_o and iord_o held at 1 for 4 cycles. reg_write_o never asserted. Total 7 cycles.
- beq with zero_i=1, then bne with zero_i=1 → pc_write_o=1 with pc_src_o=01 in BRANCH for beq. pc_write_o=0 in BRANCH for bne.
- ori (0x0D) followed by R-type add → ori: ext_zero_o=1 and alu_op_o=011 in state 9, reg_dst_o=0 in state 10. add: alu_op_o=010 in state 6, reg_dst_o=1 in state 7. instr_count_o increases by 2.
- Opcode 0x02 → with MIPS_MC_JUMP_EN: state 11, pc_src_o=10, 3 cycles total. Without it: illegal_op_o=1 for one cycle, return to FETCH, count unchanged. Reset asserted during MEM_READ → FETCH on the next cycle with no reg_write_o.
